// File: rtl/pipeline_pkg.sv
// Shared definitions for the ID/EX stage: control field layout, FSM encoding and the bubble constant.
package pipeline_pkg;

    localparam int unsigned WB_W = 2;
    localparam int unsigned M_W  = 2;
    localparam int unsigned EX_W = 4;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;
    localparam int unsigned M_MEMREAD   = 1;
    localparam int unsigned M_MEMWRITE  = 0;
    localparam int unsigned EX_REGDST   = 3;
    localparam int unsigned EX_ALUSRC   = 2;
    localparam int unsigned EX_ALUOP_LO = 0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX stage; slave = the stage, master = its environment.
interface id_ex_stage_if
    import pipeline_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic [AW-1:0]   IFID_RsAddr_i;
    logic [AW-1:0]   IFID_RtAddr_i;
    logic [AW-1:0]   IFID_RdAddr_i;
    logic [WB_W-1:0] ID_WB_i;
    logic [M_W-1:0]  ID_M_i;
    logic [EX_W-1:0] ID_EX_i;
    logic [DW-1:0]   ID_RsData_i;
    logic [DW-1:0]   ID_RtData_i;
    logic [DW-1:0]   ID_Imm_i;
    logic            flush_i;
    logic            freeze_i;

    logic [WB_W-1:0] IDEX_WB_o;
    logic [M_W-1:0]  IDEX_M_o;
    logic [EX_W-1:0] IDEX_EX_o;
    logic [DW-1:0]   IDEX_RsData_o;
    logic [DW-1:0]   IDEX_RtData_o;
    logic [DW-1:0]   IDEX_Imm_o;
    logic [AW-1:0]   IDEX_RsAddr_o;
    logic [AW-1:0]   IDEX_RtAddr_o;
    logic [AW-1:0]   IDEX_RdAddr_o;
    logic            PCWrite_o;
    logic            IFIDWrite_o;
    logic            bubble_o;

    modport master (
        output IFID_RsAddr_i, IFID_RtAddr_i, IFID_RdAddr_i,
        output ID_WB_i, ID_M_i, ID_EX_i,
        output ID_RsData_i, ID_RtData_i, ID_Imm_i,
        output flush_i, freeze_i,
        input  IDEX_WB_o, IDEX_M_o, IDEX_EX_o,
        input  IDEX_RsData_o, IDEX_RtData_o, IDEX_Imm_o,
        input  IDEX_RsAddr_o, IDEX_RtAddr_o, IDEX_RdAddr_o,
        input  PCWrite_o, IFIDWrite_o, bubble_o
    );

    modport slave (
        input  IFID_RsAddr_i, IFID_RtAddr_i, IFID_RdAddr_i,
        input  ID_WB_i, ID_M_i, ID_EX_i,
        input  ID_RsData_i, ID_RtData_i, ID_Imm_i,
        input  flush_i, freeze_i,
        output IDEX_WB_o, IDEX_M_o, IDEX_EX_o,
        output IDEX_RsData_o, IDEX_RtData_o, IDEX_Imm_o,
        output IDEX_RsAddr_o, IDEX_RtAddr_o, IDEX_RdAddr_o,
        output PCWrite_o, IFIDWrite_o, bubble_o
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose rt is read by the instruction in ID.
module hazard_detect #(
    parameter int unsigned AW = 5
) (
    input  logic          run,
    input  logic          ex_mem_read,
    input  logic [AW-1:0] ex_rt,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    output logic          haz
);

    // $0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign haz = run & ex_mem_read & (ex_rt != '0)
               & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and global freeze.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned LU_BUBBLES = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    id_ex_stage_if.slave bus
);

    localparam int unsigned CW = $clog2(LU_BUBBLES + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    ctrl_t         ctrl_q;
    logic [DW-1:0] rs_data_q;
    logic [DW-1:0] rt_data_q;
    logic [DW-1:0] imm_q;
    logic [AW-1:0] rs_addr_q;
    logic [AW-1:0] rt_addr_q;
    logic [AW-1:0] rd_addr_q;
    logic          bubble_q;
    logic          run;
    logic          haz;

    assign run = (state == RUN);

    hazard_detect #(.AW(AW)) u_hazard_detect (
        .run         (run),
        .ex_mem_read (ctrl_q.m[M_MEMREAD]),
        .ex_rt       (rt_addr_q),
        .id_rs       (bus.IFID_RsAddr_i),
        .id_rt       (bus.IFID_RtAddr_i),
        .haz         (haz)
    );

    // Flush must let the redirect through even mid-stall; freeze overrides everything.
    assign bus.PCWrite_o   = ~bus.freeze_i & (bus.flush_i | (run & ~haz));
    assign bus.IFIDWrite_o = ~bus.freeze_i & (bus.flush_i | (run & ~haz));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            cnt       <= '0;
            ctrl_q    <= BUBBLE;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rd_addr_q <= '0;
            bubble_q  <= 1'b1;
        end else if (bus.freeze_i) begin
            state <= state;
        end else if (bus.flush_i || haz || (state == STALL)) begin
            ctrl_q    <= BUBBLE;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rd_addr_q <= '0;
            bubble_q  <= 1'b1;
            if (bus.flush_i) begin
                state <= RUN;
                cnt   <= '0;
            end else if (state == RUN) begin
                // First bubble of a hazard; further bubbles are counted down in STALL.
                if (LU_BUBBLES > 1) begin
                    state <= STALL;
                    cnt   <= CW'(LU_BUBBLES - 1);
                end
            end else begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state <= RUN;
                end
            end
        end else begin
            ctrl_q.wb <= bus.ID_WB_i;
            ctrl_q.m  <= bus.ID_M_i;
            ctrl_q.ex <= bus.ID_EX_i;
            rs_data_q <= bus.ID_RsData_i;
            rt_data_q <= bus.ID_RtData_i;
            imm_q     <= bus.ID_Imm_i;
            rs_addr_q <= bus.IFID_RsAddr_i;
            rt_addr_q <= bus.IFID_RtAddr_i;
            rd_addr_q <= bus.IFID_RdAddr_i;
            bubble_q  <= 1'b0;
        end
    end

    assign bus.IDEX_WB_o     = ctrl_q.wb;
    assign bus.IDEX_M_o      = ctrl_q.m;
    assign bus.IDEX_EX_o     = ctrl_q.ex;
    assign bus.IDEX_RsData_o = rs_data_q;
    assign bus.IDEX_RtData_o = rt_data_q;
    assign bus.IDEX_Imm_o    = imm_q;
    assign bus.IDEX_RsAddr_o = rs_addr_q;
    assign bus.IDEX_RtAddr_o = rt_addr_q;
    assign bus.IDEX_RdAddr_o = rd_addr_q;
    assign bus.bubble_o      = bubble_q;

endmodule
